// File: rtl/serial_frame_sender_pkg.sv
// Shared constants and state encoding for the serial frame link (sender and receiver).
package serial_frame_sender_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CHAN,
        LEN,
        DATA,
        GAP
    } state_t;

    localparam int CH_W    = 2;
    localparam int LEN_W   = 4;
    localparam int DATA_W  = 15;
    localparam int FRAME_W = 1 + CH_W + LEN_W + DATA_W;

    localparam logic START_BIT = 1'b0;
    localparam logic IDLE_LVL  = 1'b1;

    // Move payload bit [len-1] up to the top of the data field so it leaves right after the length LSB.
    function automatic logic [DATA_W-1:0] align_payload(input logic [DATA_W-1:0] data,
                                                        input logic [LEN_W-1:0]  len);
        return data << (5'(DATA_W) - {1'b0, len});
    endfunction

endpackage

// File: rtl/serial_frame_sender_tick.sv
// Bit-time divider: counts BIT_DIV clocks per serial bit and flags the last clock of each bit.
module bit_tick_gen #(
    parameter int BIT_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running modulo-BIT_DIV counter, held at zero while cleared so a new frame starts a fresh bit.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/serial_frame_sender.sv
// Serial frame sender: accepts one request at a time and shifts out start, channel, length and payload.
module serial_frame_sender
    import serial_frame_sender_pkg::*;
#(
    parameter int BIT_DIV  = 1,
    parameter int GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CH_W-1:0]   req_ch,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_data,
    output logic              Ser_Out,
    output logic              busy,
    output logic              done
);

    localparam logic [LEN_W-1:0] GAP_RELOAD = LEN_W'(GAP_BITS - 1);

    state_t             state;
    state_t             state_next;
    logic [LEN_W-1:0]   bit_cnt;
    logic [LEN_W-1:0]   bit_cnt_next;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   len_next;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] shreg_next;
    logic               ser_q;
    logic               ser_next;
    logic               done_q;
    logic               done_next;
    logic               tick;

    bit_tick_gen #(
        .BIT_DIV(BIT_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(state == IDLE),
        .tick (tick)
    );

    // State, counters, shift register and the registered line/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            len_q   <= '0;
            shreg   <= '0;
            ser_q   <= IDLE_LVL;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            len_q   <= len_next;
            shreg   <= shreg_next;
            ser_q   <= ser_next;
            done_q  <= done_next;
        end
    end

    // Next-state logic: load on accept, then advance field by field at each bit-tick end.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        len_next     = len_q;
        shreg_next   = shreg;
        ser_next     = ser_q;
        done_next    = 1'b0;

        if (state == IDLE) begin
            ser_next = IDLE_LVL;
            if (req_valid) begin
                state_next   = START;
                bit_cnt_next = '0;
                len_next     = req_len;
                shreg_next   = {START_BIT, req_ch, req_len, align_payload(req_data, req_len)};
                ser_next     = START_BIT;
            end
        end else if (tick) begin
            bit_cnt_next = bit_cnt - LEN_W'(1);
            if (bit_cnt == '0) begin
                case (state)
                    START: begin
                        state_next   = CHAN;
                        bit_cnt_next = LEN_W'(1);
                    end
                    CHAN: begin
                        state_next   = LEN;
                        bit_cnt_next = LEN_W'(3);
                    end
                    LEN: begin
                        if (len_q != '0) begin
                            state_next   = DATA;
                            bit_cnt_next = len_q - LEN_W'(1);
                        end else begin
                            state_next   = GAP;
                            bit_cnt_next = GAP_RELOAD;
                        end
                    end
                    DATA: begin
                        state_next   = GAP;
                        bit_cnt_next = GAP_RELOAD;
                    end
                    default: begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                    end
                endcase
            end
            shreg_next = shreg << 1;
            ser_next   = (state_next == GAP || state_next == IDLE) ? IDLE_LVL : shreg[FRAME_W-2];
            done_next  = (state_next == GAP) && (state != GAP);
        end
    end

    assign Ser_Out   = ser_q;
    assign done      = done_q;
    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE);

endmodule

// File: tb/tb_serial_frame_sender.sv
// Scoreboard bench for serial_frame_sender: one instance at BIT_DIV=1, one at BIT_DIV=4.
module tb_serial_frame_sender;

    localparam int GAP = 2;

    typedef struct packed {
        logic ser;
        logic busy;
        logic done;
        logic ready;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        valid1;
    logic        ready1;
    logic [1:0]  ch1;
    logic [3:0]  len1;
    logic [14:0] data1;
    logic        ser1;
    logic        busy1;
    logic        done1;

    logic        valid4;
    logic        ready4;
    logic [1:0]  ch4;
    logic [3:0]  len4;
    logic [14:0] data4;
    logic        ser4;
    logic        busy4;
    logic        done4;

    exp_t q1[$];
    exp_t q4[$];

    int checks = 0;
    int errors = 0;

    logic [3:0]  lensTab[4] = '{4'd1, 4'd15, 4'd7, 4'd4};
    logic [14:0] dataTab[4] = '{15'h0001, 15'h5A5A, 15'h0055, 15'h7FF5};

    serial_frame_sender #(.BIT_DIV(1), .GAP_BITS(GAP)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .req_valid(valid1),
        .req_ready(ready1),
        .req_ch   (ch1),
        .req_len  (len1),
        .req_data (data1),
        .Ser_Out  (ser1),
        .busy     (busy1),
        .done     (done1)
    );

    serial_frame_sender #(.BIT_DIV(4), .GAP_BITS(GAP)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .req_valid(valid4),
        .req_ready(ready4),
        .req_ch   (ch4),
        .req_len  (len4),
        .req_data (data4),
        .Ser_Out  (ser4),
        .busy     (busy4),
        .done     (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t idleExp();
        exp_t e;
        e.ser   = 1'b1;
        e.busy  = 1'b0;
        e.done  = 1'b0;
        e.ready = 1'b1;
        return e;
    endfunction

    task automatic pushExp(input int which, input exp_t e);
        if (which == 1) q1.push_back(e);
        else            q4.push_back(e);
    endtask

    // Expected per-clock line for a frame given MSB-first bits, followed by gap and one idle clock.
    task automatic pushFrameBits(input int which, input logic [21:0] bits, input int nbits);
        int   div;
        exp_t e;
        div = (which == 1) ? 1 : 4;
        for (int b = 0; b < nbits + GAP; b++) begin
            for (int r = 0; r < div; r++) begin
                e.ser   = (b < nbits) ? bits[nbits-1-b] : 1'b1;
                e.busy  = 1'b1;
                e.done  = (b == nbits) && (r == 0);
                e.ready = 1'b0;
                pushExp(which, e);
            end
        end
        pushExp(which, idleExp());
    endtask

    // Frame model: start 0, ch MSB first, len MSB first, data[len-1] down to data[0].
    task automatic pushFrame(input int which, input logic [1:0] ch, input logic [3:0] len,
                             input logic [14:0] data);
        logic [21:0] v;
        v = {15'd0, 1'b0, ch, len};
        for (int i = int'(len) - 1; i >= 0; i--) begin
            v = {v[20:0], data[i]};
        end
        pushFrameBits(which, v, 7 + int'(len));
    endtask

    // Present a request, hold it until accepted, and queue the expected line activity.
    task automatic applyStimulus(input int which, input logic [1:0] ch, input logic [3:0] len,
                                 input logic [14:0] data, input logic [21:0] lit, input int litBits);
        int waited;
        waited = 0;
        @(negedge clk);
        if (which == 1) begin
            valid1 = 1'b1; ch1 = ch; len1 = len; data1 = data;
        end else begin
            valid4 = 1'b1; ch4 = ch; len4 = len; data4 = data;
        end
        while ((((which == 1) ? ready1 : ready4) !== 1'b1) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 300) begin
            errors++;
            $display("[TB] FAIL accept_timeout dut%0d: req_ready stayed 0, required 1", which);
        end else if (litBits > 0) begin
            pushFrameBits(which, lit, litBits);
        end else begin
            pushFrame(which, ch, len, data);
        end
        @(posedge clk);
        #1;
        if (which == 1) valid1 = 1'b0;
        else            valid4 = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input exp_t e, input logic ser, input logic bsy,
                               input logic dn, input logic rdy);
        checks += 4;
        if (ser !== e.ser) begin
            errors++;
            $display("[TB] FAIL %s.Ser_Out at %0t: got %b expected %b", tag, $time, ser, e.ser);
        end
        if (bsy !== e.busy) begin
            errors++;
            $display("[TB] FAIL %s.busy at %0t: got %b expected %b", tag, $time, bsy, e.busy);
        end
        if (dn !== e.done) begin
            errors++;
            $display("[TB] FAIL %s.done at %0t: got %b expected %b", tag, $time, dn, e.done);
        end
        if (rdy !== e.ready) begin
            errors++;
            $display("[TB] FAIL %s.req_ready at %0t: got %b expected %b", tag, $time, rdy, e.ready);
        end
    endtask

    // Monitor for the BIT_DIV=1 instance: one expected entry per clock while the queue holds any.
    always @(posedge clk) begin : mon1
        exp_t e;
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checkOutput("dut1", e, ser1, busy1, done1, ready1);
        end
    end

    // Monitor for the BIT_DIV=4 instance.
    always @(posedge clk) begin : mon4
        exp_t e;
        #1;
        if (q4.size() > 0) begin
            e = q4.pop_front();
            checkOutput("dut4", e, ser4, busy4, done4, ready4);
        end
    end

    // Hard stop in case the flow itself stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        valid1 = 1'b0; ch1 = '0; len1 = '0; data1 = '0;
        valid4 = 1'b0; ch4 = '0; len4 = '0; data4 = '0;
        repeat (2) @(negedge clk);
        pushExp(1, idleExp());
        pushExp(4, idleExp());
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] ch=2 len=5 frame");
        applyStimulus(1, 2'd2, 4'd5, 15'b10110, 22'b0_10_0101_10110, 12);
        $display("[TB] len=0 frame, request held while busy");
        applyStimulus(1, 2'd3, 4'd0, 15'h7ABC, 22'b0_11_0000, 7);
        applyStimulus(1, 2'd1, 4'd3, 15'b101, 22'd0, 0);

        $display("[TB] one frame per channel");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1, 2'(c), lensTab[c], dataTab[c], 22'd0, 0);
        end

        $display("[TB] reset mid-frame with simultaneous request");
        applyStimulus(1, 2'd1, 4'd8, 15'h00A5, 22'd0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        valid1 = 1'b1; ch1 = 2'd2; len1 = 4'd3; data1 = 15'h0007;
        q1.delete();
        repeat (4) pushExp(1, idleExp());
        repeat (3) @(negedge clk);
        rst = 1'b0;
        valid1 = 1'b0;
        applyStimulus(1, 2'd0, 4'd2, 15'b11, 22'b0_00_0010_11, 9);

        $display("[TB] BIT_DIV=4 long frame");
        applyStimulus(4, 2'd1, 4'd15, 15'h7FFF, 22'd0, 0);

        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q1.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d/%0d entries left, required 0/0", q1.size(), q4.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
